// File: rtl/otter_ex_unit.sv
// ---------------------------------------------------------------------------
// otter_ex_unit
//
// Registered execute stage of the OTTER RV32I pipeline. Combines the ALU,
// the branch address generator (jump/branch targets) and the branch
// condition generator (rs1/rs2 compare flags). All results are computed
// combinationally from the current operands and captured into output
// registers on the rising clock edge, giving a fixed one-cycle latency.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   STALL               1 = every output register holds its value
//   VALID_IN            tags the operands as a live instruction
//   SRC_A, SRC_B        ALU operands (already muxed upstream)
//   ALU_FUN             ALU operation select
//   RS1, RS2            forwarded register values for compare and JALR
//   I_TYPE, J_TYPE,
//   B_TYPE              sign-extended immediates
//   FROM_PC             PC of the executing instruction
//   RESULT              registered ALU result
//   JAL, JALR, BRANCH   registered jump/branch targets
//   BR_EQ, BR_LT,
//   BR_LTU              registered compare flags
//   VALID_OUT           registered copy of VALID_IN
// ---------------------------------------------------------------------------
module otter_ex_unit (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        STALL,
    input  logic        VALID_IN,
    input  logic [31:0] SRC_A,
    input  logic [31:0] SRC_B,
    input  logic [3:0]  ALU_FUN,
    input  logic [31:0] RS1,
    input  logic [31:0] RS2,
    input  logic [31:0] I_TYPE,
    input  logic [31:0] J_TYPE,
    input  logic [31:0] B_TYPE,
    input  logic [31:0] FROM_PC,
    output logic [31:0] RESULT,
    output logic [31:0] JAL,
    output logic [31:0] JALR,
    output logic [31:0] BRANCH,
    output logic        BR_EQ,
    output logic        BR_LT,
    output logic        BR_LTU,
    output logic        VALID_OUT
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_LUI  = 4'b1001,
        ALU_SRA  = 4'b1101
    } alu_fun_e;

    logic [31:0] result_d, result_q;
    logic [31:0] jal_d,    jal_q;
    logic [31:0] jalr_d,   jalr_q;
    logic [31:0] branch_d, branch_q;
    logic        br_eq_d,  br_eq_q;
    logic        br_lt_d,  br_lt_q;
    logic        br_ltu_d, br_ltu_q;
    logic        valid_q;

    logic [4:0]  shamt;
    logic [31:0] jalr_sum;

    assign shamt    = SRC_B[4:0];
    assign jalr_sum = RS1 + I_TYPE;

    // ALU
    always_comb begin
        // NOTE: default assigned first so every path drives result_d and no
        // latch is inferred for unlisted ALU_FUN codes.
        result_d = 32'h0;
        case (ALU_FUN)
            ALU_ADD:  result_d = SRC_A + SRC_B;
            ALU_SUB:  result_d = SRC_A - SRC_B;
            ALU_SLL:  result_d = SRC_A << shamt;
            ALU_SLT:  result_d = {31'h0, $signed(SRC_A) < $signed(SRC_B)};
            ALU_SLTU: result_d = {31'h0, SRC_A < SRC_B};
            ALU_XOR:  result_d = SRC_A ^ SRC_B;
            ALU_SRL:  result_d = SRC_A >> shamt;
            ALU_SRA:  result_d = $unsigned($signed(SRC_A) >>> shamt);
            ALU_OR:   result_d = SRC_A | SRC_B;
            ALU_AND:  result_d = SRC_A & SRC_B;
            ALU_LUI:  result_d = SRC_A;
            default:  result_d = 32'h0;
        endcase
    end

    // Branch address and branch condition generators
    always_comb begin
        jal_d    = FROM_PC + J_TYPE;
        branch_d = FROM_PC + B_TYPE;
        // Bit 0 is cleared after the wrapped sum, as JALR requires.
        jalr_d   = {jalr_sum[31:1], 1'b0};
        br_eq_d  = (RS1 == RS2);
        br_lt_d  = ($signed(RS1) < $signed(RS2));
        br_ltu_d = (RS1 < RS2);
    end

    // Output registers: capture when not stalled, reset wins over stall.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            result_q <= 32'h0;
            jal_q    <= 32'h0;
            jalr_q   <= 32'h0;
            branch_q <= 32'h0;
            br_eq_q  <= 1'b0;
            br_lt_q  <= 1'b0;
            br_ltu_q <= 1'b0;
            valid_q  <= 1'b0;
        end else if (!STALL) begin
            // NOTE: non-blocking assignments so all registers update together
            // from pre-edge values, independent of statement order.
            result_q <= result_d;
            jal_q    <= jal_d;
            jalr_q   <= jalr_d;
            branch_q <= branch_d;
            br_eq_q  <= br_eq_d;
            br_lt_q  <= br_lt_d;
            br_ltu_q <= br_ltu_d;
            valid_q  <= VALID_IN;
        end
    end

    assign RESULT    = result_q;
    assign JAL       = jal_q;
    assign JALR      = jalr_q;
    assign BRANCH    = branch_q;
    assign BR_EQ     = br_eq_q;
    assign BR_LT     = br_lt_q;
    assign BR_LTU    = br_ltu_q;
    assign VALID_OUT = valid_q;

endmodule

// File: tb/tb_otter_ex_unit.sv
// ---------------------------------------------------------------------------
// tb_otter_ex_unit
//
// Self-checking bench for otter_ex_unit. Table-driven ALU and BAG/BCG
// vectors with hand-computed expectations, plus directed sequences for
// stall, asynchronous reset and valid tagging. Inputs change on the falling
// edge; outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_otter_ex_unit;

    logic        CLK;
    logic        RST_N;
    logic        STALL;
    logic        VALID_IN;
    logic [31:0] SRC_A, SRC_B;
    logic [3:0]  ALU_FUN;
    logic [31:0] RS1, RS2;
    logic [31:0] I_TYPE, J_TYPE, B_TYPE;
    logic [31:0] FROM_PC;
    logic [31:0] RESULT, JAL, JALR, BRANCH;
    logic        BR_EQ, BR_LT, BR_LTU;
    logic        VALID_OUT;

    int pass_cnt  = 0;
    int total_cnt = 0;

    otter_ex_unit dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .STALL     (STALL),
        .VALID_IN  (VALID_IN),
        .SRC_A     (SRC_A),
        .SRC_B     (SRC_B),
        .ALU_FUN   (ALU_FUN),
        .RS1       (RS1),
        .RS2       (RS2),
        .I_TYPE    (I_TYPE),
        .J_TYPE    (J_TYPE),
        .B_TYPE    (B_TYPE),
        .FROM_PC   (FROM_PC),
        .RESULT    (RESULT),
        .JAL       (JAL),
        .JALR      (JALR),
        .BRANCH    (BRANCH),
        .BR_EQ     (BR_EQ),
        .BR_LT     (BR_LT),
        .BR_LTU    (BR_LTU),
        .VALID_OUT (VALID_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  fun;
        logic [31:0] exp;
        string       name;
    } alu_vec_t;

    typedef struct {
        logic [31:0] pc, jt, bt, it, rs1, rs2;
        logic [31:0] exp_jal, exp_branch, exp_jalr;
        logic        exp_eq, exp_lt, exp_ltu;
    } bx_vec_t;

    alu_vec_t alu_tab[12];
    bx_vec_t  bx_tab[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Drive on the falling edge, then sample just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_alu(input logic [3:0] fun, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        ALU_FUN = fun;
        SRC_A   = a;
        SRC_B   = b;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " RESULT"},    RESULT,    32'h0);
        check({tag, " JAL"},       JAL,       32'h0);
        check({tag, " JALR"},      JALR,      32'h0);
        check({tag, " BRANCH"},    BRANCH,    32'h0);
        check({tag, " flags"},     {29'h0, BR_EQ, BR_LT, BR_LTU}, 32'h0);
        check({tag, " VALID_OUT"}, {31'h0, VALID_OUT}, 32'h0);
    endtask

    initial begin
        alu_tab[0]  = '{4'b0000, 32'h0000_0001, "ADD"};
        alu_tab[1]  = '{4'b1000, 32'hFFFF_FFDF, "SUB"};
        alu_tab[2]  = '{4'b0010, 32'h0000_0001, "SLT"};
        alu_tab[3]  = '{4'b0011, 32'h0000_0000, "SLTU"};
        alu_tab[4]  = '{4'b1101, 32'hFFFF_FFFF, "SRA"};
        alu_tab[5]  = '{4'b0101, 32'h0000_7FFF, "SRL"};
        alu_tab[6]  = '{4'b0001, 32'hFFE0_0000, "SLL"};
        alu_tab[7]  = '{4'b0100, 32'hFFFF_FFE1, "XOR"};
        alu_tab[8]  = '{4'b0110, 32'hFFFF_FFF1, "OR"};
        alu_tab[9]  = '{4'b0111, 32'h0000_0010, "AND"};
        alu_tab[10] = '{4'b1001, 32'hFFFF_FFF0, "LUI"};
        alu_tab[11] = '{4'b1111, 32'h0000_0000, "ILLEGAL"};

        //              pc      jt          bt      it      rs1          rs2
        bx_tab[0] = '{32'h100, 32'hFFFF_FFFC, 32'h20, 32'h4, 32'h1001,     32'h1,
                      32'hFC, 32'h120, 32'h1004, 1'b0, 1'b0, 1'b0};
        bx_tab[1] = '{32'h0,   32'h8,         32'h0,  32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      32'h8,  32'h0,   32'h0,    1'b1, 1'b0, 1'b0};
        bx_tab[2] = '{32'h10,  32'h0,         32'h4,  32'h0, 32'h8000_0000, 32'h1,
                      32'h10, 32'h14,  32'h8000_0000, 1'b0, 1'b1, 1'b0};

        RST_N = 1'b0; STALL = 1'b0; VALID_IN = 1'b0;
        SRC_A = '0; SRC_B = '0; ALU_FUN = '0;
        RS1 = '0; RS2 = '0; I_TYPE = '0; J_TYPE = '0; B_TYPE = '0; FROM_PC = '0;

        // Reset state
        #12;
        check_all_zero("reset");
        @(negedge CLK);
        RST_N = 1'b1;

        // ALU sweep: one vector per cycle, each result one edge later.
        for (int i = 0; i < 12; i++) begin
            drive_alu(alu_tab[i].fun, 32'hFFFF_FFF0, 32'h0000_0011);
            tick();
            check({"alu ", alu_tab[i].name}, RESULT, alu_tab[i].exp);
        end

        // BAG / BCG vectors
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            FROM_PC = bx_tab[i].pc;
            J_TYPE  = bx_tab[i].jt;
            B_TYPE  = bx_tab[i].bt;
            I_TYPE  = bx_tab[i].it;
            RS1     = bx_tab[i].rs1;
            RS2     = bx_tab[i].rs2;
            tick();
            check($sformatf("bx%0d JAL", i),    JAL,    bx_tab[i].exp_jal);
            check($sformatf("bx%0d BRANCH", i), BRANCH, bx_tab[i].exp_branch);
            check($sformatf("bx%0d JALR", i),   JALR,   bx_tab[i].exp_jalr);
            check($sformatf("bx%0d flags", i), {29'h0, BR_EQ, BR_LT, BR_LTU},
                  {29'h0, bx_tab[i].exp_eq, bx_tab[i].exp_lt, bx_tab[i].exp_ltu});
        end

        // Equal compare with RS1=RS2=5
        @(negedge CLK);
        RS1 = 32'h5; RS2 = 32'h5;
        tick();
        check("bcg eq5 flags", {29'h0, BR_EQ, BR_LT, BR_LTU}, 32'h4);

        // Stall: 1+2 -> 3, hold across 3 edges with new inputs, then 10.
        drive_alu(4'b0000, 32'd1, 32'd2);
        tick();
        check("stall load", RESULT, 32'd3);
        @(negedge CLK);
        STALL = 1'b1;
        SRC_A = 32'd5; SRC_B = 32'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall hold %0d", i), RESULT, 32'd3);
        end
        @(negedge CLK);
        STALL = 1'b0;
        tick();
        check("stall release", RESULT, 32'd10);

        // Async reset between edges with nonzero outputs.
        @(negedge CLK);
        VALID_IN = 1'b1;
        tick();
        check("pre-reset valid", {31'h0, VALID_OUT}, 32'h1);
        #2;
        RST_N = 1'b0;
        #1;
        check_all_zero("async rst");
        @(negedge CLK);
        STALL = 1'b1;
        tick();
        tick();
        check_all_zero("rst+stall");
        // Release reset while stalled: still nothing captured.
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        check("post-rst stalled", RESULT, 32'h0);
        @(negedge CLK);
        STALL = 1'b0;
        tick();
        check("post-rst capture", RESULT, 32'd10);

        // VALID pattern 1,0,1 delayed by one cycle, then frozen by stall.
        @(negedge CLK); VALID_IN = 1'b1;
        tick(); check("valid p0", {31'h0, VALID_OUT}, 32'h1);
        @(negedge CLK); VALID_IN = 1'b0;
        tick(); check("valid p1", {31'h0, VALID_OUT}, 32'h0);
        @(negedge CLK); VALID_IN = 1'b1;
        tick(); check("valid p2", {31'h0, VALID_OUT}, 32'h1);
        @(negedge CLK); STALL = 1'b1; VALID_IN = 1'b0;
        tick(); check("valid frozen0", {31'h0, VALID_OUT}, 32'h1);
        tick(); check("valid frozen1", {31'h0, VALID_OUT}, 32'h1);
        @(negedge CLK); STALL = 1'b0;
        tick(); check("valid unfrozen", {31'h0, VALID_OUT}, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
